data_mem_responder: RTL

//  Memory-side responder for the core's data-memory interface (MemWrite/DataAdr/WriteData/ReadData).

---
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder.sv | 138 +++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// Data-memory bus between the core (master) and the memory responder (slave).
//   MemReq/MemWrite/DataAdr/WriteData/ByteEn : request, driven by the core
//   ReadData/MemReady/MemBusy/MemErr         : response, driven by the memory
interface data_mem_responder_if;
  logic        MemReq;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [3:0]  ByteEn;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemBusy;
  logic        MemErr;

  modport master (
    output MemReq, MemWrite, DataAdr, WriteData, ByteEn,
    input  ReadData, MemReady, MemBusy, MemErr
  );

  modport slave (
    input  MemReq, MemWrite, DataAdr, WriteData, ByteEn,
    output ReadData, MemReady, MemBusy, MemErr
  );
endinterface

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's data-memory interface.
// Accepts one load/store in IDLE, waits WAIT_STATES cycles, then pulses MemReady
// for one cycle (with MemErr on misaligned/out-of-range access). Word RAM with byte
// enables; stores commit on the edge leaving RESP.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : slave side of data_mem_responder_if (all outputs registered)
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_responder_if.slave   bus
);

  localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               acc;
  logic               in_err;

  logic               cap_write;
  logic [AW-1:0]      cap_idx;
  logic [31:0]        cap_data;
  logic [3:0]         cap_be;
  logic               cap_err;

  logic               src_write;
  logic [AW-1:0]      src_idx;
  logic               src_err;

  logic [31:0]        rd_q, rd_n;
  logic               ready_q, ready_n;
  logic               busy_q, busy_n;
  logic               err_q, err_n;
  logic               commit;

  logic [31:0]        mem [DEPTH_WORDS];

  // Full 30-bit word index is compared so high address bits never alias into the RAM.
  assign in_err = (bus.DataAdr[1:0] != 2'b00) | (bus.DataAdr[31:2] >= 30'(DEPTH_WORDS));

  // Next state, counter and registered-output values.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    acc       = 1'b0;
    src_write = cap_write;
    src_idx   = cap_idx;
    src_err   = cap_err;
    rd_n      = rd_q;
    case (state)
      S_IDLE: begin
        if (bus.MemReq) begin
          acc       = 1'b1;
          // With zero wait states RESP is entered on the accept edge itself,
          // so the response is formed from the live request.
          src_write = bus.MemWrite;
          src_idx   = bus.DataAdr[AW+1:2];
          src_err   = in_err;
          if (WAIT_STATES == 0) begin
            state_n = S_RESP;
          end else begin
            cnt_n   = CNT_W'(WAIT_STATES);
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_n = S_RESP;
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    if (state_n == S_RESP && state != S_RESP) begin
      rd_n = (src_write | src_err) ? 32'h0 : mem[src_idx];
    end
    ready_n = (state_n == S_RESP);
    busy_n  = (state_n != S_IDLE);
    err_n   = (state_n == S_RESP) & src_err;
  end

  // State, captured request and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_idx   <= '0;
      cap_data  <= '0;
      cap_be    <= '0;
      cap_err   <= 1'b0;
      rd_q      <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rd_q    <= rd_n;
      ready_q <= ready_n;
      busy_q  <= busy_n;
      err_q   <= err_n;
      if (acc) begin
        cap_write <= bus.MemWrite;
        cap_idx   <= bus.DataAdr[AW+1:2];
        cap_data  <= bus.WriteData;
        cap_be    <= bus.ByteEn;
        cap_err   <= in_err;
      end
    end
  end

  // Store commit on the edge leaving RESP; reset forces IDLE so a pending store is lost.
  assign commit = (state == S_RESP) & cap_write & ~cap_err;

  // RAM has no reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (cap_be[i]) mem[cap_idx][8*i +: 8] <= cap_data[8*i +: 8];
      end
    end
  end

  assign bus.ReadData = rd_q;
  assign bus.MemReady = ready_q;
  assign bus.MemBusy  = busy_q;
  assign bus.MemErr   = err_q;

endmodule
